// File: rtl/logic_result_serializer.sv
// Serialises a {NOR, OR} result word pair MSB first, DIV clock cycles per bit.
// Define LOGIC_SER_PARITY_EN to append an even-parity bit after the last data bit.
module logic_result_serializer #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nor_in,
  input  logic [15:0] or_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ser_data,
  output logic        ser_frame,
  output logic        busy,
  output logic        done
);

`ifdef LOGIC_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

  localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

  state_e      state_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [5:0]  bit_cnt_q;
  logic [5:0]  bit_cnt_d;
  logic [7:0]  div_cnt_q;
  logic [7:0]  div_cnt_d;
  logic        in_ready_q;
  logic        ser_data_q;
  logic        ser_frame_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end;
`ifdef LOGIC_SER_PARITY_EN
  logic        parity_q;
`endif

  // The bit on the line lives in ser_data_q; shift_q holds the bits still to go.
  assign shift_d   = {shift_q[30:0], 1'b0};
  assign bit_cnt_d = bit_cnt_q + 6'd1;
  assign div_cnt_d = div_cnt_q - 8'd1;
  assign bit_end   = (DIV == 1) || (div_cnt_q == 8'd0);

  // NOTE: all state, including the outputs, updates with <= in this one block so
  // every register sees pre-edge values; outputs are registered to stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOGIC_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid) begin
            state_q     <= SHIFT;
            shift_q     <= {nor_in[14:0], or_in, 1'b0};
            ser_data_q  <= nor_in[15];
            ser_frame_q <= 1'b1;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= DIV_RELOAD;
`ifdef LOGIC_SER_PARITY_EN
            parity_q    <= ^{nor_in, or_in};
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        SHIFT: begin
          if (!bit_end) begin
            div_cnt_q <= div_cnt_d;
          end else if (bit_cnt_q == 6'd31) begin
`ifdef LOGIC_SER_PARITY_EN
            state_q    <= PAR;
            ser_data_q <= parity_q;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= DIV_RELOAD;
`else
            state_q     <= DONE;
            ser_data_q  <= 1'b0;
            ser_frame_q <= 1'b0;
            done_q      <= 1'b1;
`endif
          end else begin
            shift_q    <= shift_d;
            ser_data_q <= shift_q[31];
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= DIV_RELOAD;
          end
        end

`ifdef LOGIC_SER_PARITY_EN
        PAR: begin
          if (!bit_end) begin
            div_cnt_q <= div_cnt_d;
          end else begin
            state_q     <= DONE;
            ser_data_q  <= 1'b0;
            ser_frame_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif

        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          bit_cnt_q  <= '0;
          div_cnt_q  <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_data  = ser_data_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/logic_result_serializer.md
LOGIC_RESULT_SERIALIZER -- requirements
Module: logic_result_serializer

Interface
REQ-001 SHALL have parameter DIV, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port nor_in, input, 16: NOR result word from the 16-bit logic unit.
REQ-005 SHALL have port or_in, input, 16: OR result word from the 16-bit logic unit.
REQ-006 SHALL have port in_valid, input, 1: nor_in/or_in are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a word pair this cycle.
REQ-008 SHALL have port ser_data, output, 1: serial data bit.
REQ-009 SHALL have port ser_frame, output, 1: high while ser_data carries a frame bit.
REQ-010 SHALL have port busy, output, 1: high from acceptance until done.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after the last frame bit.

Function
REQ-012 SHALL accept a word pair on a rising edge where in_valid=1 and in_ready=1, latching both words into a 32-bit shift register {nor_in, or_in}.
REQ-013 SHALL drive in_ready=1 only in state IDLE; in_valid during any other state is ignored, with no capture and no error.
REQ-014 SHALL implement states IDLE, SHIFT, PAR and DONE; transitions: IDLE->SHIFT on accept; SHIFT->PAR after bit 31 if parity is compiled in, else SHIFT->DONE; PAR->DONE after one bit period; DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL transmit MSB first: nor_in[15]..nor_in[0], then or_in[15]..or_in[0].
REQ-016 SHALL hold each bit on ser_data for exactly DIV cycles, counted by a divider counter that reloads at every bit boundary.
REQ-017 SHALL present the first bit in the cycle after the accept edge (latency 1); frame length is 32*DIV cycles, or 33*DIV cycles with parity.
REQ-018 SHALL hold ser_frame=1 for exactly the frame bit periods and 0 otherwise; ser_data SHALL be 0 whenever ser_frame=0.
REQ-019 SHALL assert done for exactly one cycle, in state DONE, immediately after the last bit period; busy SHALL be 1 in SHIFT, PAR and DONE.
REQ-020 SHALL accept a new pair in the cycle after done (back-to-back frames are separated by one idle cycle).
REQ-021 SHALL use a 6-bit bit counter and an 8-bit divider counter, neither wrapping within a frame; with DIV=1 the divider is bypassed, one bit per cycle.

Reset
REQ-022 SHALL, on rst=1 at any time including mid-frame, immediately force state IDLE, shift register 0, counters 0, ser_data=0, ser_frame=0, busy=0, done=0 and in_ready=0.
REQ-023 SHALL drive in_ready=1 starting with the first clock edge after rst deasserts; an aborted frame SHALL NOT resume.

Configuration
REQ-024 SHALL, when macro LOGIC_SER_PARITY_EN is defined, append one even-parity bit (XOR of all 32 data bits) after or_in[0], held DIV cycles with ser_frame=1.
REQ-025 SHALL, without LOGIC_SER_PARITY_EN, omit state PAR and transmit exactly 32 bits.

Verification
REQ-026 SHALL verify basic framing: DIV=1, nor_in=0xFFFE, or_in=0x0001 -> ser_data stream 1111111111111110 0000000000000001, ser_frame high for 32 cycles, done 1 cycle later.
REQ-027 SHALL verify bit timing: DIV=4, nor_in=0xA5A5, or_in=0x0F0F -> each bit held 4 cycles, frame 128 cycles, busy high 129 cycles.
REQ-028 SHALL verify parity: with LOGIC_SER_PARITY_EN, nor_in=0x0000, or_in=0x0001 -> 33rd bit = 1; with nor_in=0x00FF, or_in=0xFF00 -> 33rd bit = 0.
REQ-029 SHALL verify the busy case: in_valid pulsed with 0x1234/0x5678 mid-frame -> in_ready=0, no capture, the current frame is unchanged.
REQ-030 SHALL verify reset: rst asserted at bit 10 -> all outputs 0 in the same cycle; after release, in_ready=1 and a new frame transmits correctly.
REQ-031 SHALL verify back-to-back operation: in_valid held high with two successive pairs -> second accepted the cycle after done, one idle cycle between frames.
